cmd_event_arbiter: RTL and testbench
====================================

Name: cmd_event_arbiter

Overview:
Sits downstream of the per-command filter bank and turns the NUM_SIGNALS filtered command levels into a serial stream of change events for the host/CPU interface.
- Detects every level change per command and queues it as a pending event per line.
- Shares one event output port between all commands using round-robin arbitration.
- Flags overruns when a command changes again before its previous event was delivered.

Parameters:
NUM_SIGNALS, 16, number of command lines (2..64)
IDX_W, $clog2(NUM_SIGNALS), width of event index

Ports:
clk  input  1  system clock
aclr  input  1  asynchronous reset, active high
in  input  NUM_SIGNALS  filtered command levels (synchronous to clk)
ev_valid  output  1  event available on ev_index/ev_level
ev_ready  input  1  consumer accepts event when ev_valid & ev_ready
ev_index  output  IDX_W  command number of presented event
ev_level  output  1  new level of that command
pending  output  NUM_SIGNALS  per-command undelivered-event flags
overrun  output  NUM_SIGNALS  sticky per-command overrun flags
overrun_clr  input  NUM_SIGNALS  per-bit synchronous clear of overrun

Behaviour:
- Reset (aclr=1, async):
  - prev_q=0, pending=0, level_q=0, overrun=0, ptr=0.
  - ev_valid=0, ev_index=0, ev_level=0.
  - armed=0.
- Arming:
  - First clock after aclr deasserts: prev_q<=in, armed<=1, no events generated.
  - This means levels already high at reset release produce no event.
- Edge detect (armed=1): edge[i] = in[i] ^ prev_q[i]. prev_q<=in every cycle.
- Pending per line, given edge[i] and take[i] (take = line loaded into output stage this cycle):
  - edge & !pending → pending<=1, level_q<=in[i].
  - edge & pending & !take → overrun<=1, pending stays 1, level_q<=in[i] (latest level wins).
  - edge & take → pending stays 1, level_q<=in[i], no overrun (old event leaves, new one queued).
  - !edge & take → pending<=0.
- Overrun:
  - Sticky; cleared only by overrun_clr[i] or aclr.
  - A set and a clear of the same bit in one cycle → set wins.
- Output stage, 2-state FSM:
  - EMPTY (ev_valid=0): if any pending, pick the first pending line searching ptr, ptr+1, …, NUM_SIGNALS-1, 0, …, ptr-1. Load ev_index/ev_level from that line, assert take, ev_valid<=1, go to FULL.
  - FULL (ev_valid=1): outputs held stable while ev_ready=0. On ev_ready=1, the handshake completes. In the same cycle, if any pending line other than the one just taken exists, load the next winner (back-to-back, one event per clock); otherwise ev_valid<=0, go to EMPTY.
  - On every load, ptr<=winner+1, wrapping NUM_SIGNALS-1 → 0.
- Latency:
  - Edge on in sampled at clock t → pending at t+1 → ev_valid at t+2 when output is EMPTY.
  - Sustained throughput: 1 event/clk with ev_ready tied high.
- Arbitration sees pending as registered at the start of the cycle. An edge arriving in the same cycle is not eligible until the next cycle.
- Fairness: a continuously pending line waits at most NUM_SIGNALS-1 grants.
- ev_level is the level at load time. Later edges on that line queue a new event and do not alter the presented outputs.
- aclr mid-handshake: everything is cleared immediately and the presented event is lost. The block re-arms as above.

Decomposition:
- Shared package (bsk_pkg or equivalent):
  - cmd_event_t struct {idx, level}.
  - Constant CMD_NUM_DEFAULT = 16.
- One sub-module, rr_pick: combinational round-robin priority encoder.
  - Inputs: req[N-1:0], ptr.
  - Outputs: any, grant_idx.
  - Implemented as a rotate, find-first, un-rotate.
  - Reused later by other shared-resource arbiters.
- The top holds the registers and FSM.

Test Plan:
- Reset release with in=16'h0005 held → no ev_valid for 10 clocks, pending=0.
- After arming, in 0→16'h0008 at clock t with ev_ready=1 → at t+2: ev_valid=1, ev_index=3, ev_level=1; at t+3: ev_valid=0.
- in simultaneously 0→16'h8421, ev_ready=1, ptr=0 → events in order 0, 5, 10, 15 on four consecutive clocks, all ev_level=1. Repeat with ptr=6 → order 10, 15, 0, 5.
- ev_ready=0; line 2 toggles 0→1→0 on two successive clocks → overrun[2]=1, one event idx 2 level 0 once ready rises. Then overrun_clr[2]=1 → overrun[2]=0.
- Hold ev_ready=0 for 20 clocks while FULL → ev_index/ev_level stable. Assert ev_ready → next pending winner follows with no bubble.
- aclr pulse while ev_valid=1 and pending=16'hFFFF → outputs and flags 0 the same cycle, then no events until new edges after re-arm.

Source files
------------

// File: rtl/cmd_event_arbiter_pkg.sv
// Shared types and constants for the command event arbiter and related arbiters.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cmd_event_arbiter_pkg;

    // Default number of command lines fed by the filter bank.
    localparam int CMD_NUM_DEFAULT = 16;

    // Event index field is sized for the largest supported bank (64 lines),
    // so the struct stays the same type for every NUM_SIGNALS setting.
    localparam int CMD_IDX_MAX_W = 6;

    typedef struct packed {
        logic [CMD_IDX_MAX_W-1:0] idx;
        logic                     level;
    } cmd_event_t;

endpackage

// File: rtl/cmd_event_arbiter_rr_pick.sv
// Round-robin priority pick: first set request at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether to act on the grant.
module rr_pick #(
    parameter int N     = 16,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic             any,
    output logic [PTR_W-1:0] grant_idx
);

    localparam logic [PTR_W:0] N_L = (PTR_W+1)'(N);

    logic [2*N-1:0]   dbl;
    logic [N-1:0]     rot;
    logic [PTR_W-1:0] first;
    logic [PTR_W:0]   sum;

    // Rotate so that the request at ptr lands in bit 0.
    assign dbl = {req, req} >> ptr;
    assign rot = dbl[N-1:0];

    // Find-first set bit in the rotated vector (lowest index wins).
    always_comb begin
        any   = 1'b0;
        first = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                any   = 1'b1;
                first = PTR_W'(i);
            end
        end
    end

    // Un-rotate: add ptr back, modulo N (N need not be a power of two).
    always_comb begin
        sum = {1'b0, first} + {1'b0, ptr};
        if (sum >= N_L) begin
            grant_idx = PTR_W'(sum - N_L);
        end else begin
            grant_idx = PTR_W'(sum);
        end
    end

endmodule

// File: rtl/cmd_event_arbiter.sv
// Turns filtered command levels into a serial stream of change events, round-robin shared.
// Latency: edge sampled -> pending next cycle -> ev_valid the cycle after; 1 event/clk sustained.
// Backpressure: ev_valid/ev_ready; presented event held while stalled, further changes queue or overrun.
module cmd_event_arbiter
    import cmd_event_arbiter_pkg::*;
#(
    parameter int NUM_SIGNALS = CMD_NUM_DEFAULT,
    parameter int IDX_W       = $clog2(NUM_SIGNALS)
) (
    input  logic                   clk,
    input  logic                   aclr,
    input  logic [NUM_SIGNALS-1:0] in,
    output logic                   ev_valid,
    input  logic                   ev_ready,
    output logic [IDX_W-1:0]       ev_index,
    output logic                   ev_level,
    output logic [NUM_SIGNALS-1:0] pending,
    output logic [NUM_SIGNALS-1:0] overrun,
    input  logic [NUM_SIGNALS-1:0] overrun_clr
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic                   armed;
    logic [NUM_SIGNALS-1:0] prev_q;
    logic [NUM_SIGNALS-1:0] pending_q;
    logic [NUM_SIGNALS-1:0] level_q;
    logic [NUM_SIGNALS-1:0] overrun_q;
    logic [0:0]             state_q;
    logic [0:0]             state_d;
    cmd_event_t             ev_q;
    logic [IDX_W-1:0]       ptr_q;

    logic [NUM_SIGNALS-1:0] edge_det;
    logic [NUM_SIGNALS-1:0] cur_mask;
    logic [NUM_SIGNALS-1:0] req;
    logic [NUM_SIGNALS-1:0] take;
    logic [NUM_SIGNALS-1:0] ovr_set;
    logic                   any;
    logic [IDX_W-1:0]       win;
    logic                   load;
    logic [IDX_W-1:0]       ptr_next;

    // Nothing counts as a change until prev_q has captured a real sample.
    assign edge_det = armed ? (in ^ prev_q) : '0;

    // One-hot of the line currently sitting in the output stage.
    always_comb begin
        cur_mask = '0;
        for (int i = 0; i < NUM_SIGNALS; i++) begin
            cur_mask[i] = (ev_q.idx == CMD_IDX_MAX_W'(i));
        end
    end

    // While FULL, the presented line is not a candidate for the back-to-back reload.
    assign req = (state_q == ST_FULL) ? (pending_q & ~cur_mask) : pending_q;

    rr_pick #(
        .N     (NUM_SIGNALS),
        .PTR_W (IDX_W)
    ) u_pick (
        .req       (req),
        .ptr       (ptr_q),
        .any       (any),
        .grant_idx (win)
    );

    // Load when the output stage is empty or is being drained this cycle.
    assign load = any && ((state_q == ST_EMPTY) || ev_ready);

    // Per-line take strobe and overrun detection for this cycle.
    always_comb begin
        take = '0;
        if (load) begin
            take[win] = 1'b1;
        end
        ovr_set = edge_det & pending_q & ~take;
    end

    // Next output-stage state and round-robin pointer after the winner.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = ST_FULL;
        end else if ((state_q == ST_FULL) && ev_ready) begin
            state_d = ST_EMPTY;
        end
        if (win == IDX_W'(NUM_SIGNALS - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = win + IDX_W'(1);
        end
    end

    // Edge tracking, per-line pending/level queue and sticky overrun flags.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            armed     <= 1'b0;
            prev_q    <= '0;
            pending_q <= '0;
            level_q   <= '0;
            overrun_q <= '0;
        end else begin
            armed     <= 1'b1;
            prev_q    <= in;
            // An edge always (re)queues; a take without a new edge retires the line.
            pending_q <= (pending_q & ~take) | edge_det;
            // Latest level wins while an event waits.
            level_q   <= (level_q & ~edge_det) | (in & edge_det);
            // Set beats clear when both hit the same bit.
            overrun_q <= (overrun_q & ~overrun_clr) | ovr_set;
        end
    end

    // Output stage: captures the winner's index and level, holds them while stalled.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state_q <= ST_EMPTY;
            ev_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                ev_q.idx   <= CMD_IDX_MAX_W'(win);
                ev_q.level <= level_q[win];
                ptr_q      <= ptr_next;
            end
        end
    end

    assign ev_valid = (state_q == ST_FULL);
    assign ev_index = ev_q.idx[IDX_W-1:0];
    assign ev_level = ev_q.level;
    assign pending  = pending_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_cmd_event_arbiter.sv
// Randomized and directed bench for cmd_event_arbiter against a queue-level reference model.
// Latency: n/a.
// Backpressure: ev_ready driven by the bench (held, toggled and randomized).
module tb_cmd_event_arbiter;

    localparam int N = 16;
    localparam int W = 4;

    logic         clk;
    logic         aclr;
    logic [N-1:0] in_sig;
    logic         ev_valid;
    logic         ev_ready;
    logic [W-1:0] ev_index;
    logic         ev_level;
    logic [N-1:0] pending;
    logic [N-1:0] overrun;
    logic [N-1:0] overrun_clr;

    int n_cmp;
    int n_bad;

    // Reference model state: per-line queue of at most one event, plus output slot.
    bit         m_armed;
    bit [N-1:0] m_prev;
    bit         m_pend [N];
    bit         m_lvl  [N];
    bit         m_ovr  [N];
    bit         m_valid;
    int         m_idx;
    bit         m_level;
    int         m_ptr;

    int acc[$];

    cmd_event_arbiter #(.NUM_SIGNALS(N), .IDX_W(W)) dut (
        .clk         (clk),
        .aclr        (aclr),
        .in          (in_sig),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_index    (ev_index),
        .ev_level    (ev_level),
        .pending     (pending),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] vec(input bit a [N]);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = a[i];
        return v;
    endfunction

    task automatic model_reset();
        m_armed = 0;
        m_prev  = '0;
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0; m_lvl[i] = 0; m_ovr[i] = 0;
        end
        m_valid = 0; m_idx = 0; m_level = 0; m_ptr = 0;
    endtask

    // One clock of the behavioural rules, using the inputs present at the edge.
    task automatic model_step();
        bit [N-1:0] e;
        bit [N-1:0] tk;
        bit [N-1:0] setv;
        int w;
        e  = m_armed ? (in_sig ^ m_prev) : '0;
        tk = '0;
        w  = -1;
        if (!m_valid || ev_ready) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (w < 0 && m_pend[j] && !(m_valid && j == m_idx)) w = j;
            end
        end
        if (w >= 0) begin
            tk[w]   = 1;
            m_valid = 1;
            m_idx   = w;
            m_level = m_lvl[w];
            m_ptr   = (w + 1) % N;
        end else if (m_valid && ev_ready) begin
            m_valid = 0;
        end
        for (int i = 0; i < N; i++) begin
            setv[i] = e[i] && m_pend[i] && !tk[i];
            if (e[i]) begin
                m_pend[i] = 1;
                m_lvl[i]  = in_sig[i];
            end else if (tk[i]) begin
                m_pend[i] = 0;
            end
            m_ovr[i] = (m_ovr[i] && !overrun_clr[i]) || setv[i];
        end
        m_prev  = in_sig;
        m_armed = 1;
    endtask

    task automatic compare_all();
        check("ev_valid", ev_valid, m_valid);
        if (m_valid) begin
            check("ev_index", ev_index, m_idx);
            check("ev_level", ev_level, m_level);
        end
        check("pending", pending, vec(m_pend));
        check("overrun", overrun, vec(m_ovr));
    endtask

    task automatic cycle();
        if (!aclr && ev_valid && ev_ready) acc.push_back(int'(ev_index));
        @(posedge clk);
        if (aclr) model_reset();
        else model_step();
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Asynchronous reset: flags must drop without waiting for a clock edge.
    task automatic pulse_reset();
        aclr = 1'b1;
        #1;
        model_reset();
        check("rst_valid", ev_valid, 1'b0);
        check("rst_flags", {pending, overrun}, '0);
        cycle();
        aclr = 1'b0;
    endtask

    task automatic check_order(input string tag, input int exp[$]);
        check({tag, "_count"}, acc.size(), exp.size());
        for (int i = 0; i < exp.size() && i < acc.size(); i++) check(tag, acc[i], exp[i]);
        acc.delete();
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        aclr = 1'b1; in_sig = 16'h0005; ev_ready = 1'b1; overrun_clr = '0;
        model_reset();
        #12;
        check("por_valid", ev_valid, 1'b0);
        check("por_flags", {pending, overrun}, '0);
        aclr = 1'b0;

        // Levels already high at release produce nothing.
        run(10);
        check("arm_pending", pending, 16'h0000);
        check("arm_events", acc.size(), 0);

        // Single edge: pending, then presented, then drained.
        in_sig = '0; pulse_reset(); cycle();
        in_sig = 16'h0008;
        cycle();
        check("lat_pend", pending, 16'h0008);
        check("lat_nv", ev_valid, 1'b0);
        cycle();
        check("lat_valid", ev_valid, 1'b1);
        check("lat_idx", ev_index, 3);
        check("lat_lvl", ev_level, 1'b1);
        cycle();
        check("lat_drain", ev_valid, 1'b0);
        acc.delete();

        // Simultaneous edges from ptr=0, then from ptr=6.
        in_sig = '0; pulse_reset(); cycle();
        in_sig = 16'h8421; run(8);
        check_order("rr0", '{0, 5, 10, 15});
        in_sig = 16'h8401; run(4);
        check_order("rr_line5", '{5});
        in_sig = 16'h0020; run(8);
        check_order("rr6", '{10, 15, 0, 5});

        // Overrun: line 2 toggles twice while line 0 occupies the stalled output.
        ev_ready = 1'b0;
        in_sig = 16'h0021; run(2);
        in_sig = 16'h0025; cycle();
        in_sig = 16'h0021; cycle();
        check("ovr_set", overrun[2], 1'b1);
        check("ovr_pend", pending[2], 1'b1);
        ev_ready = 1'b1; run(4);
        check_order("ovr_order", '{0, 2});
        overrun_clr = 16'h0004; cycle();
        overrun_clr = '0;
        check("ovr_clr", overrun[2], 1'b0);

        // Long stall with several lines queued, then back-to-back drain.
        ev_ready = 1'b0;
        in_sig = in_sig ^ 16'h0F0F; run(22);
        ev_ready = 1'b1; run(12);
        acc.delete();

        // Reset mid-handshake with every line pending.
        ev_ready = 1'b0;
        in_sig = ~in_sig; run(3);
        in_sig = ~in_sig; cycle();
        check("all_pend", pending, 16'hFFFF);
        check("all_valid", ev_valid, 1'b1);
        pulse_reset();
        ev_ready = 1'b1; run(6);
        check("rearm_events", acc.size(), 0);

        // Randomized traffic, backpressure, clears and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] tog;
            tog = '0;
            for (int b = 0; b < N; b++) if ($urandom_range(0, 9) == 0) tog[b] = 1'b1;
            in_sig      = in_sig ^ tog;
            ev_ready    = ($urandom_range(0, 3) != 0);
            overrun_clr = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            if ($urandom_range(0, 499) == 0) pulse_reset();
            else cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
